// File: rtl/date_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | date_pkg : shared widths, month codes and reset date for the date     |
// | counter.                                                              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package date_pkg;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    localparam logic [DAY_W-1:0]  RESET_DAY   = 5'd1;
    localparam logic [MON_W-1:0]  RESET_MONTH = JAN;
    localparam logic [YEAR_W-1:0] RESET_YEAR  = 7'd0;

endpackage : date_pkg
`default_nettype wire

// File: rtl/month_len.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | month_len : days in a given month/year (0 for an illegal month).      |
// | Macro: DATE_LEAP_YEAR_EN enables 29-day February when year[1:0]==0.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module month_len
    import date_pkg::*;
(
    input  logic [MON_W-1:0]  i_month,
    input  logic [YEAR_W-1:0] i_year,
    output logic [DAY_W-1:0]  o_days
);

    logic [DAY_W-1:0] w_feb_days;
    logic             w_unused_year;

    assign w_unused_year = ^i_year;

`ifdef DATE_LEAP_YEAR_EN
    // Divisible-by-4 is exact across 2000..2099, so the two LSBs suffice.
    assign w_feb_days = (i_year[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
    assign w_feb_days = 5'd28;
`endif

    always_comb begin
        o_days = '0;
        case (i_month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: o_days = 5'd31;
            APR, JUN, SEP, NOV:                o_days = 5'd30;
            FEB:                               o_days = w_feb_days;
            default:                           o_days = '0;
        endcase
    end

endmodule : month_len
`default_nettype wire

// File: rtl/date_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | date_counter : day/month/year counter advanced by hour-wrap ticks,    |
// | with validated parallel load and gated date bus.                      |
// | Macro: DATE_LEAP_YEAR_EN (leap February, via month_len).              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module date_counter
    import date_pkg::*;
#(
    parameter int YEAR_MAX = 99
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [DAY_W-1:0]  load_day,
    input  logic [MON_W-1:0]  load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic              enable,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic              load_err,
    output logic              year_carry,
    output logic [15:0]       databus
);

    localparam logic [YEAR_W-1:0] c_YEAR_MAX = YEAR_W'(YEAR_MAX);

    logic [DAY_W-1:0]  r_day,   w_day_nxt;
    logic [MON_W-1:0]  r_month, w_month_nxt;
    logic [YEAR_W-1:0] r_year,  w_year_nxt;
    logic              r_load_err, w_load_err_nxt;
    logic              r_year_carry, w_year_carry_nxt;

    logic [DAY_W-1:0]  w_cur_days;
    logic [DAY_W-1:0]  w_load_days;
    logic              w_load_valid;

    month_len u_len_cur (
        .i_month (r_month),
        .i_year  (r_year),
        .o_days  (w_cur_days)
    );

    month_len u_len_load (
        .i_month (load_month),
        .i_year  (load_year),
        .o_days  (w_load_days)
    );

    // An illegal month yields 0 days, which also fails the day range check.
    assign w_load_valid = (load_month >= JAN) && (load_month <= DEC) &&
                          (load_year <= c_YEAR_MAX) &&
                          (load_day != '0) && (load_day <= w_load_days);

    always_comb begin
        w_day_nxt        = r_day;
        w_month_nxt      = r_month;
        w_year_nxt       = r_year;
        w_load_err_nxt   = r_load_err;
        w_year_carry_nxt = 1'b0;
        if (load) begin
            if (w_load_valid) begin
                w_day_nxt      = load_day;
                w_month_nxt    = load_month;
                w_year_nxt     = load_year;
                w_load_err_nxt = 1'b0;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (day_tick) begin
            if (r_day < w_cur_days) begin
                w_day_nxt = r_day + 5'd1;
            end else begin
                w_day_nxt = RESET_DAY;
                if (r_month == DEC) begin
                    w_month_nxt = JAN;
                    if (r_year == c_YEAR_MAX) begin
                        w_year_nxt       = '0;
                        w_year_carry_nxt = 1'b1;
                    end else begin
                        w_year_nxt = r_year + 7'd1;
                    end
                end else begin
                    w_month_nxt = r_month + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_day        <= RESET_DAY;
            r_month      <= RESET_MONTH;
            r_year       <= RESET_YEAR;
            r_load_err   <= 1'b0;
            r_year_carry <= 1'b0;
        end else begin
            r_day        <= w_day_nxt;
            r_month      <= w_month_nxt;
            r_year       <= w_year_nxt;
            r_load_err   <= w_load_err_nxt;
            r_year_carry <= w_year_carry_nxt;
        end
    end

    assign day        = r_day;
    assign month      = r_month;
    assign year       = r_year;
    assign load_err   = r_load_err;
    assign year_carry = r_year_carry;
    assign databus    = {r_year, r_month, r_day} & {16{enable}};

endmodule : date_counter
`default_nettype wire

// File: tb/tb_date_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_date_counter : directed scoreboard bench for date_counter.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_date_counter;

    typedef struct {
        string      tag;
        logic [4:0] d;
        logic [3:0] m;
        logic [6:0] y;
        logic       err;
        logic       carry;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  load_day = '0;
    logic [3:0]  load_month = '0;
    logic [6:0]  load_year = '0;
    logic        enable = 1'b0;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic        load_err;
    logic        year_carry;
    logic [15:0] databus;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    date_counter #(.YEAR_MAX(99)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .day_tick   (day_tick),
        .load       (load),
        .load_day   (load_day),
        .load_month (load_month),
        .load_year  (load_year),
        .enable     (enable),
        .day        (day),
        .month      (month),
        .year       (year),
        .load_err   (load_err),
        .year_carry (year_carry),
        .databus    (databus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        logic [15:0] bus_exp;
        bus_exp = {e.y, e.m, e.d} & {16{enable}};
        check({e.tag, ".day"},   32'(day),        32'(e.d));
        check({e.tag, ".month"}, 32'(month),      32'(e.m));
        check({e.tag, ".year"},  32'(year),       32'(e.y));
        check({e.tag, ".err"},   32'(load_err),   32'(e.err));
        check({e.tag, ".carry"}, 32'(year_carry), 32'(e.carry));
        check({e.tag, ".bus"},   32'(databus),    32'(bus_exp));
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then compare after the edge.
    task automatic step(input string tag, input logic tk, input logic ld,
                        input logic [4:0] ld_d, input logic [3:0] ld_m, input logic [6:0] ld_y,
                        input logic [4:0] ed, input logic [3:0] em, input logic [6:0] ey,
                        input logic eerr, input logic ecarry);
        exp_t e;
        @(negedge clk);
        day_tick   = tk;
        load       = ld;
        load_day   = ld_d;
        load_month = ld_m;
        load_year  = ld_y;
        e.tag = tag; e.d = ed; e.m = em; e.y = ey; e.err = eerr; e.carry = ecarry;
        sb.push_back(e);
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        load     = 1'b0;
        check_all(sb.pop_front());
    endtask

    initial begin
        exp_t r;
        #12;
        r.tag = "reset"; r.d = 5'd1; r.m = 4'd1; r.y = 7'd0; r.err = 1'b0; r.carry = 1'b0;
        check_all(r);
        @(negedge clk);
        clear_n = 1'b1;

        step("hold",      0, 0, 0, 0, 0,            1, 1, 0,   0, 0);
        step("ld300424",  0, 1, 30, 4, 24,          30, 4, 24, 0, 0);
        step("apr_roll",  1, 0, 0, 0, 0,            1, 5, 24,  0, 0);
        step("ld300124",  0, 1, 30, 1, 24,          30, 1, 24, 0, 0);
        step("jan30_t",   1, 0, 0, 0, 0,            31, 1, 24, 0, 0);
        step("jan_roll",  1, 0, 0, 0, 0,            1, 2, 24,  0, 0);
        step("ld280224",  0, 1, 28, 2, 24,          28, 2, 24, 0, 0);
`ifdef DATE_LEAP_YEAR_EN
        step("feb28_24",  1, 0, 0, 0, 0,            29, 2, 24, 0, 0);
        step("feb29_24",  1, 0, 0, 0, 0,            1, 3, 24,  0, 0);
        step("ld290224",  0, 1, 29, 2, 24,          29, 2, 24, 0, 0);
`else
        step("feb28_24",  1, 0, 0, 0, 0,            1, 3, 24,  0, 0);
        step("ld290224",  0, 1, 29, 2, 24,          1, 3, 24,  1, 0);
`endif
        step("ld280223",  0, 1, 28, 2, 23,          28, 2, 23, 0, 0);
        step("feb28_23",  1, 0, 0, 0, 0,            1, 3, 23,  0, 0);
        step("ld290223",  0, 1, 29, 2, 23,          1, 3, 23,  1, 0);

        step("ld311299",  0, 1, 31, 12, 99,         31, 12, 99, 0, 0);
        step("ywrap",     1, 0, 0, 0, 0,            1, 1, 0,   0, 1);
        step("carry_off", 0, 0, 0, 0, 0,            1, 1, 0,   0, 0);
        step("ld311299b", 0, 1, 31, 12, 99,         31, 12, 99, 0, 0);
        step("ld_tick99", 1, 1, 31, 12, 99,         31, 12, 99, 0, 0);

        step("bad_apr31", 0, 1, 31, 4, 10,          31, 12, 99, 1, 0);
        step("err_stick", 1, 0, 0, 0, 0,            1, 1, 0,   1, 1);
        step("bad_mon13", 0, 1, 1, 13, 10,          1, 1, 0,   1, 0);
        step("bad_yr100", 0, 1, 1, 1, 100,          1, 1, 0,   1, 0);
        step("bad_day0",  0, 1, 0, 1, 10,           1, 1, 0,   1, 0);
        step("ld150610",  0, 1, 15, 6, 10,          15, 6, 10, 0, 0);

        enable = 1'b1;
        step("ld_tick05", 1, 1, 10, 3, 5,           10, 3, 5,  0, 0);
        check("bus_const", 32'(databus), 32'({7'd5, 4'd3, 5'd10}));
        step("held1",     1, 0, 0, 0, 0,            11, 3, 5,  0, 0);
        step("held2",     1, 0, 0, 0, 0,            12, 3, 5,  0, 0);
        step("held3",     1, 0, 0, 0, 0,            13, 3, 5,  0, 0);
        enable = 1'b0;
        #1;
        check("bus_gate", 32'(databus), 32'd0);

        step("bad_set",   0, 1, 31, 2, 20,          13, 3, 5,  1, 0);
        @(negedge clk);
        day_tick = 1'b1;
        #2;
        clear_n = 1'b0;
        #1;
        r.tag = "async_rst"; r.d = 5'd1; r.m = 4'd1; r.y = 7'd0; r.err = 1'b0; r.carry = 1'b0;
        check_all(r);
        @(posedge clk);
        #1;
        r.tag = "rst_hold";
        check_all(r);
        day_tick = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        step("post_rst",  0, 0, 0, 0, 0,            1, 1, 0,   0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_date_counter
`default_nettype wire
